// File: rtl/dpwm_pkg.sv
// Shared constants and helpers for the lab-board PWM generator.
// Segment codes are active-low, bit order g..a.
package dpwm_pkg;

    localparam int DUTY_MAX      = 100;
    localparam int PERIOD_COUNTS = 100;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        MODE_DUTY = 1'b0,
        MODE_FREQ = 1'b1
    } mode_t;

    typedef enum logic {
        OUT_BUCK   = 1'b0,
        OUT_BRIDGE = 1'b1
    } out_sel_t;

    // Non-numeric glyphs live above 9 in the digit code space.
    localparam bcd_t DIG_BLANK = 4'd14;
    localparam bcd_t DIG_F     = 4'd15;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_code(bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            DIG_F:   s = SEG_F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Splits a 0..127 value into {hundreds, tens, ones}.
    function automatic logic [11:0] to_bcd3(logic [6:0] v);
        logic [6:0] r;
        bcd_t       h;
        bcd_t       t;
        bcd_t       o;
        h = (v >= 7'd100) ? 4'd1 : 4'd0;
        r = (v >= 7'd100) ? v - 7'd100 : v;
        t = 4'(r / 7'd10);
        o = 4'(r % 7'd10);
        return {h, t, o};
    endfunction

endpackage

// File: rtl/dpwm_if.sv
// Board-side pins of the PWM generator: buttons, switches, gate drives and display.
interface dpwm_if;
    logic       boton_aumentar;
    logic       boton_disminuir;
    logic       seleccion_funcion;
    logic       seleccion_salida;
    logic       BUCK_Gate;
    logic       Full_Bridge;
    logic [3:0] anodos_7seg;
    logic [7:0] catodos_7seg;

    modport master (
        output boton_aumentar, boton_disminuir, seleccion_funcion, seleccion_salida,
        input  BUCK_Gate, Full_Bridge, anodos_7seg, catodos_7seg
    );

    modport slave (
        input  boton_aumentar, boton_disminuir, seleccion_funcion, seleccion_salida,
        output BUCK_Gate, Full_Bridge, anodos_7seg, catodos_7seg
    );
endinterface

// File: rtl/dpwm_btn.sv
// Push-button front end: 2-FF synchronizer, hold-time debounce and one pulse per press.
module dpwm_btn #(
    parameter int DB_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] db_cnt;
    logic          fired;

    // fired stays set until the button drops, which suppresses auto-repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            db_cnt <= '0;
            fired  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (!sync[1]) begin
                db_cnt <= '0;
                fired  <= 1'b0;
            end else if (!fired) begin
                if (db_cnt == CW'(DB_CYCLES - 1)) begin
                    press <= 1'b1;
                    fired <= 1'b1;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dpwm.sv
// Lab-board digital PWM: button-adjusted duty/frequency, buck/full-bridge routing
// and a 4-digit multiplexed display of the setting being adjusted.
module dpwm #(
    parameter int DB_CYCLES    = 1,
    parameter int REFRESH_BITS = 16,
    parameter int DUTY_STEP    = 10,
    parameter int FREQ_MAX     = 7
) (
    input  logic CLK_FPGA_BOARD,
    input  logic reinicio,
    dpwm_if.slave pins
);

    import dpwm_pkg::*;

    localparam int FW    = $clog2(FREQ_MAX + 1);
    localparam int PRE_W = FREQ_MAX;
    localparam int RW    = REFRESH_BITS + 2;

    logic             inc_p;
    logic             dec_p;
    logic [1:0]       func_sync;
    logic [1:0]       sel_sync;
    mode_t            mode;
    logic [6:0]       duty_pend;
    logic [6:0]       duty_act;
    logic [FW-1:0]    freq_pend;
    logic [FW-1:0]    freq_act;
    out_sel_t         sel_act;
    out_sel_t         sel_q;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_limit;
    logic             tick;
    logic [6:0]       period_cnt;
    logic             pwm_q;
    logic [RW-1:0]    refresh_cnt;
    logic [1:0]       digit_sel;
    logic [11:0]      duty_bcd;
    bcd_t             cur_digit;

    dpwm_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_inc (
        .clk   (CLK_FPGA_BOARD),
        .rst   (reinicio),
        .btn   (pins.boton_aumentar),
        .press (inc_p)
    );

    dpwm_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_dec (
        .clk   (CLK_FPGA_BOARD),
        .rst   (reinicio),
        .btn   (pins.boton_disminuir),
        .press (dec_p)
    );

    assign mode = mode_t'(func_sync[1]);

    always_ff @(posedge CLK_FPGA_BOARD or posedge reinicio) begin
        if (reinicio) begin
            func_sync <= '0;
            sel_sync  <= '0;
            duty_pend <= 7'd50;
            freq_pend <= '0;
        end else begin
            func_sync <= {func_sync[0], pins.seleccion_funcion};
            sel_sync  <= {sel_sync[0], pins.seleccion_salida};
            if (inc_p ^ dec_p) begin
                if (mode == MODE_DUTY) begin
                    if (inc_p)
                        duty_pend <= (duty_pend >= 7'(DUTY_MAX - DUTY_STEP)) ?
                                     7'(DUTY_MAX) : duty_pend + 7'(DUTY_STEP);
                    else
                        duty_pend <= (duty_pend <= 7'(DUTY_STEP)) ?
                                     7'd0 : duty_pend - 7'(DUTY_STEP);
                end else begin
                    if (inc_p) begin
                        if (freq_pend != FW'(FREQ_MAX))
                            freq_pend <= freq_pend + 1'b1;
                    end else if (freq_pend != '0) begin
                        freq_pend <= freq_pend - 1'b1;
                    end
                end
            end
        end
    end

    // Low freq_act bits set: prescaler wraps every 2**freq_act clocks.
    assign pre_limit = ~({PRE_W{1'b1}} << freq_act);
    assign tick      = (pre_cnt == pre_limit);

    always_ff @(posedge CLK_FPGA_BOARD or posedge reinicio) begin
        if (reinicio) begin
            pre_cnt          <= '0;
            period_cnt       <= '0;
            duty_act         <= 7'd50;
            freq_act         <= '0;
            sel_act          <= OUT_BUCK;
            sel_q            <= OUT_BUCK;
            pwm_q            <= 1'b0;
            pins.BUCK_Gate   <= 1'b0;
            pins.Full_Bridge <= 1'b0;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
                if (period_cnt == 7'(PERIOD_COUNTS - 1)) begin
                    period_cnt <= '0;
                    duty_act   <= duty_pend;
                    freq_act   <= freq_pend;
                    sel_act    <= out_sel_t'(sel_sync[1]);
                end else begin
                    period_cnt <= period_cnt + 7'd1;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            // sel_q lags sel_act by one cycle so it stays paired with pwm_q.
            pwm_q            <= (period_cnt < duty_act);
            sel_q            <= sel_act;
            pins.BUCK_Gate   <= (sel_q == OUT_BUCK)   ? pwm_q : 1'b0;
            pins.Full_Bridge <= (sel_q == OUT_BRIDGE) ? pwm_q : 1'b0;
        end
    end

    assign digit_sel = refresh_cnt[RW-1 -: 2];

    always_comb begin
        duty_bcd  = to_bcd3(duty_pend);
        cur_digit = DIG_BLANK;
        if (mode == MODE_FREQ) begin
            case (digit_sel)
                2'd3:    cur_digit = DIG_F;
                2'd0:    cur_digit = 4'(freq_pend);
                default: cur_digit = DIG_BLANK;
            endcase
        end else begin
            case (digit_sel)
                2'd2:    cur_digit = duty_bcd[11:8];
                2'd1:    cur_digit = duty_bcd[7:4];
                2'd0:    cur_digit = duty_bcd[3:0];
                default: cur_digit = DIG_BLANK;
            endcase
        end
    end

    always_ff @(posedge CLK_FPGA_BOARD or posedge reinicio) begin
        if (reinicio) begin
            refresh_cnt       <= '0;
            pins.anodos_7seg  <= 4'b1110;
            pins.catodos_7seg <= 8'hFF;
        end else begin
            refresh_cnt       <= refresh_cnt + 1'b1;
            pins.anodos_7seg  <= ~(4'b0001 << digit_sel);
            pins.catodos_7seg <= {1'b1, seg_code(cur_digit)};
        end
    end

endmodule

// File: tb/tb_dpwm.sv
// Randomized self-checking bench for dpwm; a settings model predicts PWM high time
// per period, output routing and the display glyphs.
module tb_dpwm;

    logic clk = 1'b0;
    logic rst;

    dpwm_if pins();

    dpwm #(
        .DB_CYCLES    (1),
        .REFRESH_BITS (2),
        .DUTY_STEP    (10),
        .FREQ_MAX     (7)
    ) dut (
        .CLK_FPGA_BOARD (clk),
        .reinicio       (rst),
        .pins           (pins)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    int m_duty;
    int m_freq;
    int m_func;
    int m_sel;
    int act_freq;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks_total++;
        if (observed == expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    function automatic int seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            15:      return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic modelReset();
        m_duty   = 50;
        m_freq   = 0;
        m_func   = 0;
        m_sel    = 0;
        act_freq = 0;
    endtask

    task automatic setSwitches(input int func, input int sel);
        @(negedge clk);
        pins.seleccion_funcion = func[0];
        pins.seleccion_salida  = sel[0];
        m_func = func;
        m_sel  = sel;
        repeat (4) @(negedge clk);
    endtask

    task automatic pressButtons(input int inc, input int dec, input int hold);
        @(negedge clk);
        pins.boton_aumentar  = inc[0];
        pins.boton_disminuir = dec[0];
        repeat (hold) @(negedge clk);
        pins.boton_aumentar  = 1'b0;
        pins.boton_disminuir = 1'b0;
        repeat (4) @(negedge clk);
        if (inc != dec) begin
            if (m_func == 0) begin
                if (inc != 0) m_duty = (m_duty + 10 > 100) ? 100 : m_duty + 10;
                else          m_duty = (m_duty - 10 < 0)   ? 0   : m_duty - 10;
            end else begin
                if (inc != 0) m_freq = (m_freq == 7) ? 7 : m_freq + 1;
                else          m_freq = (m_freq == 0) ? 0 : m_freq - 1;
            end
        end
    endtask

    // op: 0 inc, 1 dec, 2 both, 3 toggle function switch, 4 toggle output switch
    task automatic applyStimulus(input int op);
        int hold;
        hold = int'($urandom_range(1, 4));
        case (op)
            0:       pressButtons(1, 0, hold);
            1:       pressButtons(0, 1, hold);
            2:       pressButtons(1, 1, hold);
            3:       setSwitches(1 - m_func, m_sel);
            default: setSwitches(m_func, 1 - m_sel);
        endcase
    endtask

    task automatic checkDisplay(input string tag);
        int seen [4];
        int expd [4];
        int bad;
        int idx;
        bad = 0;
        for (int d = 0; d < 4; d++) seen[d] = -1;
        if (m_func == 0) begin
            expd[3] = 14;
            expd[2] = m_duty / 100;
            expd[1] = (m_duty / 10) % 10;
            expd[0] = m_duty % 10;
        end else begin
            expd[3] = 15;
            expd[2] = 14;
            expd[1] = 14;
            expd[0] = m_freq;
        end
        repeat (4) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            case (pins.anodos_7seg)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) bad++;
            else seen[idx] = int'(pins.catodos_7seg);
        end
        checkOutput({tag, "_anode_onehot"}, bad, 0);
        for (int d = 0; d < 4; d++)
            checkOutput($sformatf("%s_digit%0d", tag, d), seen[d], 128 | seg_of(expd[d]));
    endtask

    // Any window of one full period holds exactly duty * 2**freq high clocks.
    task automatic measurePwm(input string tag);
        int n;
        int high;
        int other;
        repeat ((100 << act_freq) + 20) @(negedge clk);
        act_freq = m_freq;
        n     = 100 << m_freq;
        high  = 0;
        other = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (m_sel == 0) begin
                high  += int'(pins.BUCK_Gate);
                other += int'(pins.Full_Bridge);
            end else begin
                high  += int'(pins.Full_Bridge);
                other += int'(pins.BUCK_Gate);
            end
        end
        checkOutput({tag, "_high_clocks"}, high, m_duty << m_freq);
        checkOutput({tag, "_idle_output"}, other, 0);
    endtask

    task automatic waitRiseBuck(input string tag);
        int   ok;
        logic prev;
        ok   = 0;
        prev = pins.BUCK_Gate;
        for (int c = 0; c < 2000 && ok == 0; c++) begin
            @(negedge clk);
            if (pins.BUCK_Gate && !prev) ok = 1;
            prev = pins.BUCK_Gate;
        end
        checkOutput({tag, "_rise_seen"}, ok, 1);
    endtask

    initial begin
        int op;
        pins.boton_aumentar    = 1'b0;
        pins.boton_disminuir   = 1'b0;
        pins.seleccion_funcion = 1'b0;
        pins.seleccion_salida  = 1'b0;
        rst = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rst_buck",   int'(pins.BUCK_Gate), 0);
        checkOutput("rst_bridge", int'(pins.Full_Bridge), 0);
        checkOutput("rst_anodes", int'(pins.anodos_7seg), 4'b1110);
        checkOutput("rst_dp",     int'(pins.catodos_7seg[7]), 1);
        rst = 1'b0;

        checkDisplay("init");
        measurePwm("init");

        pressButtons(1, 0, 2);
        checkDisplay("step60");
        measurePwm("step60");

        for (int i = 0; i < 6; i++) pressButtons(1, 0, 1);
        checkDisplay("sat100");
        measurePwm("sat100");
        for (int i = 0; i < 11; i++) pressButtons(0, 1, 3);
        checkDisplay("sat0");
        measurePwm("sat0");

        for (int i = 0; i < 5; i++) pressButtons(1, 0, 2);
        setSwitches(1, 0);
        pressButtons(1, 0, 2);
        pressButtons(1, 0, 2);
        checkDisplay("freq2");
        measurePwm("freq2");

        waitRiseBuck("selmid");
        repeat (20) @(negedge clk);
        setSwitches(1, 1);
        checkOutput("selmid_buck_still", int'(pins.BUCK_Gate), 1);
        checkOutput("selmid_bridge_idle", int'(pins.Full_Bridge), 0);
        measurePwm("bridge");

        pressButtons(1, 1, 2);
        checkDisplay("both_freq");

        for (int i = 0; i < 8; i++) pressButtons(1, 0, 1);
        checkDisplay("freqmax");
        pressButtons(1, 1, 1);
        checkDisplay("freqmax_both");
        for (int i = 0; i < 8; i++) pressButtons(0, 1, 1);
        checkDisplay("freq0");
        act_freq = 7;
        measurePwm("freq0");

        setSwitches(0, 1);
        pressButtons(1, 1, 3);
        checkDisplay("both_duty");
        measurePwm("both_duty");

        for (int i = 0; i < 25; i++) begin
            op = int'($urandom_range(0, 4));
            if (op == 0 && m_func == 1 && m_freq >= 2) op = 1;
            applyStimulus(op);
            checkDisplay($sformatf("rnd%0d", i));
            measurePwm($sformatf("rnd%0d", i));
        end

        setSwitches(0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        waitRiseBuck("rstmid");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_buck",   int'(pins.BUCK_Gate), 0);
        checkOutput("rstmid_bridge", int'(pins.Full_Bridge), 0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkDisplay("after_rst");
        measurePwm("after_rst");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
